// File: rtl/axis_pattern_gen_if.sv
// AXI4-Stream bundle between the pattern generator and its sink.
interface axis_pattern_gen_if #(
  parameter int DATA_W = 64
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic [DATA_W/8-1:0] tkeep;

  modport master (
    output tvalid, tdata, tlast, tkeep,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tlast, tkeep,
    output tready
  );
endinterface

// File: rtl/axis_pattern_gen.sv
// AXI4-Stream traffic generator with windowed throughput/stall monitor.
// Define AXIS_PATTERN_GEN_PRBS_EN to build the PRBS-31 payload for mode 3.
module axis_pattern_gen #(
  parameter int DATA_W        = 64,
  parameter int LEN_W         = 16,
  parameter int GAP_W         = 8,
  parameter int WINDOW_CYCLES = 10000,
  parameter int CNT_W         = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic [1:0]           i_mode,
  input  logic [LEN_W-1:0]     i_pkt_len,
  input  logic [GAP_W-1:0]     i_gap,
  axis_pattern_gen_if.master   m_axis,
  output logic                 o_busy,
  output logic [31:0]          o_pkt_cnt,
  output logic [CNT_W-1:0]     o_thr_cnt,
  output logic [CNT_W-1:0]     o_stall_cnt,
  output logic                 o_thr_valid
);

  localparam int TIC_W =
    (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_load;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [GAP_W-1:0]  r_gcnt;
  logic [1:0]        r_mode;
  logic [31:0]       r_seq;
  logic [31:0]       r_pkt_cnt;
  logic [TIC_W-1:0]  r_tic;
  logic [CNT_W-1:0]  r_acc_beat;
  logic [CNT_W-1:0]  r_acc_stall;
  logic [CNT_W-1:0]  r_thr;
  logic [CNT_W-1:0]  r_stall;
  logic              r_thr_valid;

  logic              w_send;
  logic              w_fire;
  logic              w_last;
  logic              w_eop;
  logic              w_tic_end;
  logic [LEN_W-1:0]  w_len_in;
  logic [15:0]       w_len16;
  logic [DATA_W-1:0] w_idx_ext;
  logic [DATA_W-1:0] w_data;
  logic [CNT_W-1:0]  w_beat_sum;
  logic [CNT_W-1:0]  w_stall_sum;

  assign w_send    = (r_state == S_SEND);
  assign w_fire    = w_send && m_axis.tready;
  assign w_last    = (r_idx == r_len - LEN_W'(1));
  assign w_eop     = w_fire && w_last;
  assign w_len_in  = (i_pkt_len == '0) ? LEN_W'(1) : i_pkt_len;
  assign w_len16   = 16'(r_len);
  assign w_idx_ext = DATA_W'(r_idx);
  assign w_tic_end = (r_tic == TIC_W'(WINDOW_CYCLES - 1));

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_enable) begin
          w_next = S_SEND;
          w_load = 1'b1;
        end
      end
      S_SEND: begin
        if (w_eop) begin
          w_load = 1'b1;
          if (!i_enable)          w_next = S_IDLE;
          else if (i_gap == '0)   w_next = S_SEND;
          else                    w_next = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gcnt == GAP_W'(1))
          w_next = i_enable ? S_SEND : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_len     <= LEN_W'(1);
      r_idx     <= '0;
      r_gcnt    <= '0;
      r_mode    <= '0;
      r_seq     <= '0;
      r_pkt_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_len  <= w_len_in;
        r_mode <= i_mode;
        r_gcnt <= i_gap;
        r_idx  <= '0;
      end else if (w_fire) begin
        r_idx <= r_idx + LEN_W'(1);
      end else if (r_state == S_GAP) begin
        r_gcnt <= r_gcnt - GAP_W'(1);
      end
      if (w_eop) begin
        r_seq     <= r_seq + 32'd1;
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end
    end
  end

`ifdef AXIS_PATTERN_GEN_PRBS_EN
  logic [30:0] r_lfsr;

  // x^31 + x^28 + 1, stepped only on accepted PRBS beats
  always_ff @(posedge clk) begin
    if (rst)
      r_lfsr <= 31'h7FFFFFFF;
    else if (w_fire && r_mode == 2'd3)
      r_lfsr <= {r_lfsr[29:0], r_lfsr[30] ^ r_lfsr[27]};
  end
`endif

  always_comb begin
    w_data = '0;
    if (w_send) begin
      unique case (r_mode)
        2'd0: w_data = '0;
        2'd1: w_data = w_idx_ext;
        2'd2: w_data = (r_idx == '0) ?
                       DATA_W'({w_len16, r_seq}) : w_idx_ext;
`ifdef AXIS_PATTERN_GEN_PRBS_EN
        2'd3: w_data = {(DATA_W/32){1'b0, r_lfsr}};
`else
        2'd3: w_data = w_idx_ext;
`endif
        default: w_data = '0;
      endcase
    end
  end

  assign w_beat_sum = (w_fire && r_acc_beat != CNT_MAX) ?
                      r_acc_beat + CNT_W'(1) : r_acc_beat;
  assign w_stall_sum =
    (w_send && !m_axis.tready && r_acc_stall != CNT_MAX) ?
    r_acc_stall + CNT_W'(1) : r_acc_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tic       <= '0;
      r_acc_beat  <= '0;
      r_acc_stall <= '0;
      r_thr       <= '0;
      r_stall     <= '0;
      r_thr_valid <= 1'b0;
    end else if (w_tic_end) begin
      r_tic       <= '0;
      r_acc_beat  <= '0;
      r_acc_stall <= '0;
      r_thr       <= w_beat_sum;
      r_stall     <= w_stall_sum;
      r_thr_valid <= 1'b1;
    end else begin
      r_tic       <= r_tic + TIC_W'(1);
      r_acc_beat  <= w_beat_sum;
      r_acc_stall <= w_stall_sum;
      r_thr_valid <= 1'b0;
    end
  end

  assign m_axis.tvalid = w_send;
  assign m_axis.tdata  = w_data;
  assign m_axis.tlast  = w_send && w_last;
  assign m_axis.tkeep  = '1;
  assign o_busy        = (r_state != S_IDLE);
  assign o_pkt_cnt     = r_pkt_cnt;
  assign o_thr_cnt     = r_thr;
  assign o_stall_cnt   = r_stall;
  assign o_thr_valid   = r_thr_valid;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Directed bench for axis_pattern_gen: packets, gaps, stalls,
// header payload, window monitor, enable drop and reset.
module tb_axis_pattern_gen;
  localparam int DW = 64;
  localparam int LW = 16;
  localparam int GW = 8;
  localparam int WC = 100;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic [LW-1:0] len;
  logic [GW-1:0] gap;
  logic          busy;
  logic [31:0]   pkt;
  logic [CW-1:0] thr;
  logic [CW-1:0] stl;
  logic          thv;

  axis_pattern_gen_if #(.DATA_W(DW)) axis ();

  axis_pattern_gen #(
    .DATA_W(DW), .LEN_W(LW), .GAP_W(GW),
    .WINDOW_CYCLES(WC), .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (en),
    .i_mode     (mode),
    .i_pkt_len  (len),
    .i_gap      (gap),
    .m_axis     (axis),
    .o_busy     (busy),
    .o_pkt_cnt  (pkt),
    .o_thr_cnt  (thr),
    .o_stall_cnt(stl),
    .o_thr_valid(thv)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_hold = 1'b0;
  bit prev_v = 1'b0;

  logic [DW-1:0] bd[$];
  bit            bl[$];
  int            bc[$];
  int            vr[$];
  int            lc[$];

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    bit            sv;
    logic [DW-1:0] sd;
    logic          sl;
    if (axis.tvalid && !prev_v) vr.push_back(cyc);
    prev_v = axis.tvalid;
    if (axis.tvalid && axis.tready) begin
      bd.push_back(axis.tdata);
      bl.push_back(axis.tlast);
      bc.push_back(cyc);
      if (axis.tlast) lc.push_back(cyc);
    end
    sv = axis.tvalid && !axis.tready;
    sd = axis.tdata;
    sl = axis.tlast;
    @(posedge clk);
    #1;
    cyc++;
    if (chk_hold && sv) begin
      check("hold_valid", 64'(axis.tvalid), 64'd1);
      check("hold_data", axis.tdata, sd);
      check("hold_last", 64'(axis.tlast), 64'(sl));
    end
  endtask

  task automatic clear();
    bd.delete();
    bl.delete();
    bc.delete();
    vr.delete();
    lc.delete();
    prev_v = axis.tvalid;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    axis.tready = 1'b1;
    step();
    step();
    rst = 1'b0;
    clear();
  endtask

  task automatic run_pkts(int drop_at, bit toggle);
    int i;
    en = 1'b1;
    for (i = 0; i < 400; i++) begin
      if (toggle) axis.tready = ~axis.tready;
      step();
      if (bd.size() >= drop_at) en = 1'b0;
      if (!en && !busy) break;
    end
    check("run_done", 64'(i < 400), 64'd1);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 100; i++) begin
      if (!busy) break;
      step();
    end
    check("idle_wait", 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c0;
    int i;
    int p0;
    logic [30:0] l;

    rst = 1'b1;
    en = 1'b0;
    mode = 2'd0;
    len = '0;
    gap = '0;
    axis.tready = 1'b1;
    do_reset();

    check("rst_tvalid", 64'(axis.tvalid), 64'd0);
    check("rst_tdata", axis.tdata, 64'd0);
    check("rst_tlast", 64'(axis.tlast), 64'd0);
    check("rst_tkeep", 64'(axis.tkeep), 64'hFF);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pkt", 64'(pkt), 64'd0);
    check("rst_thr", 64'(thr), 64'd0);
    check("rst_stall", 64'(stl), 64'd0);
    check("rst_thv", 64'(thv), 64'd0);

    // len 4, gap 0, mode 1: 8 back-to-back packets
    len = 16'd4; gap = 8'd0; mode = 2'd1;
    c0 = cyc;
    run_pkts(29, 1'b0);
    check("t1_beats", 64'(bd.size()), 64'd32);
    for (int k = 0; k < bd.size(); k++) begin
      check("t1_data", bd[k], 64'(k % 4));
      check("t1_last", 64'(bl[k]), 64'(k % 4 == 3));
      check("t1_cycle", 64'(bc[k]), 64'(c0 + 1 + k));
    end
    check("t1_pkt", 64'(pkt), 64'd8);
    check("t1_busy", 64'(busy), 64'd0);

    // len 3, gap 2, tready toggling
    do_reset();
    len = 16'd3; gap = 8'd2; mode = 2'd1;
    chk_hold = 1'b1;
    run_pkts(10, 1'b1);
    chk_hold = 1'b0;
    axis.tready = 1'b1;
    check("t2_beats", 64'(bd.size()), 64'd12);
    for (int k = 0; k < bd.size(); k++) begin
      check("t2_data", bd[k], 64'(k % 3));
      check("t2_last", 64'(bl[k]), 64'(k % 3 == 2));
    end
    check("t2_npkt", 64'(lc.size()), 64'd4);
    check("t2_nrise", 64'(vr.size()), 64'd4);
    for (int k = 0; k + 1 < vr.size() && k < lc.size(); k++)
      check("t2_gap", 64'(vr[k+1] - lc[k]), 64'd3);
    check("t2_pkt", 64'(pkt), 64'd4);

    // mode 2 header, len 2, 3 packets
    do_reset();
    len = 16'd2; gap = 8'd0; mode = 2'd2;
    run_pkts(5, 1'b0);
    check("t3_beats", 64'(bd.size()), 64'd6);
    if (bd.size() == 6) begin
      check("t3_hdr0", bd[0], 64'h0000_0002_0000_0000);
      check("t3_b1", bd[1], 64'd1);
      check("t3_hdr1", bd[2], 64'h0000_0002_0000_0001);
      check("t3_hdr2", bd[4], 64'h0000_0002_0000_0002);
    end

    // window monitor: 25 stalls in a 100-cycle window
    do_reset();
    len = 16'd4; gap = 8'd0; mode = 2'd1;
    en = 1'b1;
    for (i = 0; i < 300; i++) begin
      step();
      if (thv) break;
    end
    check("t4_first_pulse", 64'(i), 64'(WC - 1));
    for (int k = 0; k < WC; k++) begin
      axis.tready = (k < 25) ? 1'b0 : 1'b1;
      step();
    end
    check("t4_thv", 64'(thv), 64'd1);
    check("t4_thr", 64'(thr), 64'd75);
    check("t4_stall", 64'(stl), 64'd25);
    axis.tready = 1'b1;
    step();
    check("t4_thv_pulse", 64'(thv), 64'd0);
    en = 1'b0;
    wait_idle();

    // drop enable at beat 1 of a len-8 packet
    clear();
    p0 = int'(pkt);
    len = 16'd8; gap = 8'd0; mode = 2'd1;
    run_pkts(1, 1'b0);
    check("t5_beats", 64'(bd.size()), 64'd8);
    if (bd.size() == 8) begin
      check("t5_last", 64'(bl[7]), 64'd1);
      check("t5_data7", bd[7], 64'd7);
    end
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_tvalid", 64'(axis.tvalid), 64'd0);
    check("t5_pkt", 64'(pkt), 64'(p0 + 1));

    // reset in the middle of a packet
    clear();
    en = 1'b1;
    for (i = 0; i < 50; i++) begin
      step();
      if (bd.size() == 5) break;
    end
    check("t6_reach", 64'(bd.size()), 64'd5);
    rst = 1'b1;
    step();
    check("t6_tvalid", 64'(axis.tvalid), 64'd0);
    check("t6_tdata", axis.tdata, 64'd0);
    check("t6_tlast", 64'(axis.tlast), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_pkt", 64'(pkt), 64'd0);
    check("t6_thr", 64'(thr), 64'd0);
    check("t6_stall", 64'(stl), 64'd0);
    check("t6_thv", 64'(thv), 64'd0);
    rst = 1'b0;
    en = 1'b0;

    // mode 3 payload
    do_reset();
    len = 16'd4; gap = 8'd0; mode = 2'd3;
    run_pkts(5, 1'b0);
    check("t7_beats", 64'(bd.size()), 64'd8);
    l = 31'h7FFFFFFF;
    for (int k = 0; k < bd.size(); k++) begin
`ifdef AXIS_PATTERN_GEN_PRBS_EN
      check("t7_prbs", bd[k], {2{1'b0, l}});
      l = {l[29:0], l[30] ^ l[27]};
`else
      check("t7_mode3", bd[k], 64'(k % 4));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule
